sha256_256: RTL and testbench
=============================

Name: sha256_256

Overview:
- Fully pipelined SHA-256 engine for fixed 32-byte (256-bit) messages.
- Accepts one message per clock and emits its 256-bit digest a fixed number of cycles later.
- Padding is implicit: one 512-bit block per message.
- Used as a throughput hash core; the upstream source drives in_vld with no back-pressure.

Parameters:
- none. Message length is fixed at 32 bytes and latency is fixed at 65 cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  256  message bytes; byte j occupies in_data[8j+7:8j]. Byte 0 is the first message byte.
- in_vld  in  1  in_data is valid this cycle; may be high on every cycle.
- out_hash  out  256  digest {H0,H1,...,H7}; H0 in [255:224], standard big-endian digest, byte 0 in [255:248].
- out_vld  out  1  out_hash is valid this cycle.

Behaviour:
- Reset (async, active-high): out_vld=0, out_hash=0, all stage valid bits cleared. Any in-flight messages are discarded and never appear at the output. Datapath stage registers need not be reset.
- No handshake or back-pressure: every cycle with in_vld=1 is accepted. Each accepted message yields exactly one out_vld pulse. Order is preserved.
- Latency: in_vld sampled at edge k gives out_vld=1 and out_hash valid after edge k+65. Back-to-back inputs give back-to-back outputs. Gaps are preserved.
- When out_vld=0, out_hash holds its last value. Only out_vld is meaningful.
- Block construction (combinational at input):
  - W0..W7 = message words, big-endian: W0={byte0,byte1,byte2,byte3}, ..., W7={byte28..byte31}.
  - W8=0x80000000, W9..W14=0, W15=0x00000100 (bit length 256).
- Stage 0 (edge k): register W0..W15 and valid. Working vars a..h = initial H (0x6a09e667, 0xbb67ae85, 0x3c6ef372, 0xa54ff53a, 0x510e527f, 0x9b05688c, 0x1f83d9ab, 0x5be0cd19).
- Round stages r=0..63 (edges k+1..k+64): one SHA-256 compression round per stage using constant K[r] and W[r].
  - T1=h+Σ1(e)+Ch(e,f,g)+K[r]+W[r]; T2=Σ0(a)+Maj(a,b,c).
  - Shift: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
  - The 16-word message window is carried with each stage: W[t]=σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16] for t≥16.
- All additions are modulo 2^32 (drop carries).
- Σ0=ROTR2^ROTR13^ROTR22; Σ1=ROTR6^ROTR11^ROTR25; σ0=ROTR7^ROTR18^SHR3; σ1=ROTR17^ROTR19^SHR10.
- Final stage (edge k+65): Hi = initial Hi + working var i, mod 2^32. Register out_hash and out_vld.
- Valid bit travels alongside data through all 66 register stages.
- in_vld deasserted: pipeline continues draining; bubbles propagate as out_vld=0.
- Reset asserted mid-stream: outputs go low immediately. The first out_vld after release corresponds to the first input sampled after release, 65 cycles later.

Test Plan:
- All-zero message: in_data=0, in_vld for 1 cycle -> exactly one out_vld pulse 65 cycles later. out_hash=66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925.
- Bytes 0x00..0x1f: in_data=0x1f1e1d...020100 -> out_hash=630dcd2966c4336691125448bbb25b4ff412a49c732db2c8abc1b8581bd710dd.
- 5 random 32-byte messages on consecutive cycles -> 5 consecutive out_vld cycles, in order, each matching a software SHA-256 model.
- Gapped input (valid, idle 3 cycles, valid) -> outputs reproduce the same gap pattern with correct digests.
- Assert rst 20 cycles into a 5-message burst -> out_vld stays 0 until new inputs arrive. A new message after release produces a correct digest 65 cycles later.
- Idle after reset with in_vld=0 -> out_vld=0 and out_hash=0 indefinitely.

Source files
------------

// File: rtl/sha256_256.sv
// rtl/sha256_256.sv - fully pipelined SHA-256 for fixed 32-byte messages, one message per clock
module sha256_256 (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] in_data,
    input  logic         in_vld,
    output logic [255:0] out_hash,
    output logic         out_vld
);

    localparam logic [255:0] H_INIT = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Working state packed {a,b,c,d,e,f,g,h}, a in the top word.
    function automatic logic [255:0] round_step(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + big_s1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Window word j sits at [32j +: 32]; word 0 is the one consumed this round.
    function automatic logic [511:0] next_window(input logic [511:0] w);
        logic [31:0] w_new;
        w_new = small_s1(w[14*32 +: 32]) + w[9*32 +: 32] + small_s0(w[1*32 +: 32]) + w[0 +: 32];
        return {w_new, w[511:32]};
    endfunction

    logic [511:0] blk;
    logic [511:0] win [0:63];
    logic [255:0] wv  [0:64];
    logic         vld [0:64];
    logic [255:0] final_sum;

    always_comb begin
        blk = '0;
        for (int j = 0; j < 8; j++) begin
            blk[32*j +: 32] = {in_data[8*(4*j) +: 8], in_data[8*(4*j+1) +: 8],
                               in_data[8*(4*j+2) +: 8], in_data[8*(4*j+3) +: 8]};
        end
        blk[8*32 +: 32]  = 32'h80000000;
        blk[15*32 +: 32] = 32'h00000100;
    end

    assign wv[0] = H_INIT;

    always_ff @(posedge clk) begin
        win[0] <= blk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld[0] <= 1'b0;
        end else begin
            vld[0] <= in_vld;
        end
    end

    for (genvar r = 0; r < 64; r++) begin : g_round
        always_ff @(posedge clk) begin
            wv[r+1] <= round_step(wv[r], win[r][31:0], K[r]);
        end

        if (r < 63) begin : g_win
            always_ff @(posedge clk) begin
                win[r+1] <= next_window(win[r]);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld[r+1] <= 1'b0;
            end else begin
                vld[r+1] <= vld[r];
            end
        end
    end

    always_comb begin
        final_sum = '0;
        for (int i = 0; i < 8; i++) begin
            final_sum[32*i +: 32] = H_INIT[32*i +: 32] + wv[64][32*i +: 32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_hash <= '0;
        end else begin
            out_vld <= vld[64];
            if (vld[64]) begin
                out_hash <= final_sum;
            end
        end
    end

endmodule

// File: tb/tb_sha256_256.sv
// tb/tb_sha256_256.sv - scoreboard bench for sha256_256 with a reference SHA-256 model
module tb_sha256_256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] in_data = '0;
    logic         in_vld = 1'b0;
    logic [255:0] out_hash;
    logic         out_vld;

    sha256_256 dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .out_hash (out_hash),
        .out_vld  (out_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [255:0] hash;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    localparam logic [31:0] KR [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straightforward one-block SHA-256: full 64-word schedule, then compression.
    function automatic logic [255:0] sha_ref(input logic [255:0] msg);
        logic [31:0] w [0:63];
        logic [31:0] hv [0:7];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int t = 0; t < 8; t++)
            w[t] = {msg[32*t +: 8], msg[32*t+8 +: 8], msg[32*t+16 +: 8], msg[32*t+24 +: 8]};
        w[8] = 32'h80000000;
        for (int t = 9; t < 15; t++) w[t] = 32'h0;
        w[15] = 32'd256;
        for (int t = 16; t < 64; t++) begin
            s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
        e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KR[t] + w[t];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d, hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
    endfunction

    // Output lands at the negedge 66 posedge-counts after the driving negedge.
    task automatic send(input logic [255:0] msg, input logic [255:0] exp);
        exp_t x;
        @(negedge clk);
        in_data = msg;
        in_vld  = 1'b1;
        x.due   = cyc + 66;
        x.hash  = exp;
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_vld = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (out_vld) begin
            if (q.size() == 0) begin
                check("spurious_out_vld", 256'(out_vld), 256'd0);
            end else begin
                exp_t x;
                x = q.pop_front();
                check("latency", 256'(cyc), 256'(x.due));
                check("digest", out_hash, x.hash);
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            exp_t x;
            x = q.pop_front();
            check("missing_out_vld", 256'(out_vld), 256'd1);
        end
    end

    initial begin
        logic [255:0] m;
        logic [255:0] seq_msg;
        int           waited;

        repeat (3) @(negedge clk);
        check("reset_out_vld", 256'(out_vld), 256'd0);
        check("reset_out_hash", out_hash, 256'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_out_vld", 256'(out_vld), 256'd0);
        check("idle_out_hash", out_hash, 256'd0);

        send(256'd0, 256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925);
        idle(1);
        for (int j = 0; j < 32; j++) seq_msg[8*j +: 8] = 8'(j);
        send(seq_msg, 256'h630dcd2966c4336691125448bbb25b4ff412a49c732db2c8abc1b8581bd710dd);
        idle(80);

        for (int i = 0; i < 5; i++) begin
            m = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send(m, sha_ref(m));
        end
        idle(70);

        m = {8{32'hdeadbeef}};
        send(m, sha_ref(m));
        idle(4);
        m = {8{32'h01234567}};
        send(m, sha_ref(m));
        idle(1);
        m = '1;
        send(m, sha_ref(m));
        idle(80);

        for (int i = 0; i < 5; i++) begin
            m = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send(m, sha_ref(m));
        end
        idle(15);
        #2;
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        check("midreset_out_vld", 256'(out_vld), 256'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("post_reset_out_vld", 256'(out_vld), 256'd0);

        m = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        send(m, sha_ref(m));
        idle(1);

        waited = 0;
        while (q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() != 0) check("drain_timeout", 256'(q.size()), 256'd0);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
